// File: rtl/mem_to_reg_if.sv
// Register-bus payload types and the SRAM-style memory port bundle used by mem_to_reg.

package mem_to_reg_pkg;

  localparam int unsigned RegAw = 32;
  localparam int unsigned RegDw = 32;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [RegAw-1:0]       addr;
    logic [RegDw-1:0]       wdata;
    logic [RegDw/8-1:0]     wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                   ready;
    logic [RegDw-1:0]       rdata;
    logic                   error;
  } reg_rsp_t;

endpackage

// Memory-side request/grant/response port. The initiator is the master, the bridge the slave.
interface mem_to_reg_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic            req;
  logic            gnt;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            rerror;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rdata, rvalid, rerror
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rdata, rvalid, rerror
  );

endinterface

// File: rtl/mem_to_reg.sv
// Bridge from an SRAM-style memory port to the register bus. Each granted memory request
// masters exactly one register-bus transaction and returns exactly one rvalid pulse.
// An optional timeout aborts accesses to peripherals that never assert ready.

module mem_to_reg #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter type         req_t         = mem_to_reg_pkg::reg_req_t,
  parameter type         rsp_t         = mem_to_reg_pkg::reg_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mem_to_reg_if.slave mem,
  output req_t        reg_req_o,
  input  rsp_t        reg_rsp_i
);

  // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned SW   = DW / 8;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [CntW-1:0] cnt_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            rerror_q;
  logic            timeout_hit;

  // Last permitted wait cycle: the access aborts here unless ready arrives in the same cycle.
  if (TimeoutCycles > 0) begin : g_timeout
    assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // Grant is combinational so a request can be accepted in the same cycle rvalid is returned.
  assign mem.gnt = (state_q == StIdle) && mem.req && !rst_i;

  // Transaction FSM: capture on grant, hold the bus request, complete on ready or timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerror_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem.req) begin
            we_q    <= mem.we;
            addr_q  <= mem.addr;
            wdata_q <= mem.wdata;
            wstrb_q <= mem.wstrb;
            cnt_q   <= '0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (reg_rsp_i.ready) begin
            // Writes return zero data so the memory side never sees stale peripheral data.
            rdata_q  <= we_q ? '0 : reg_rsp_i.rdata;
            rerror_q <= reg_rsp_i.error;
            rvalid_q <= 1'b1;
            state_q  <= StIdle;
          end else if (timeout_hit) begin
            // Abort drops valid without a handshake to recover from a dead peripheral.
            rdata_q  <= '0;
            rerror_q <= 1'b1;
            rvalid_q <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Register-bus request is driven only in ACCESS, straight from captured flops.
  always_comb begin
    reg_req_o = '0;
    if (state_q == StAccess) begin
      reg_req_o.valid          = 1'b1;
      reg_req_o.write          = we_q;
      reg_req_o.addr[AW-1:0]   = addr_q;
      reg_req_o.wdata          = wdata_q;
      reg_req_o.wstrb          = wstrb_q;
    end
  end

  assign mem.rvalid = rvalid_q;
  assign mem.rdata  = rdata_q;
  assign mem.rerror = rerror_q;

endmodule

// File: tb/tb_mem_to_reg.sv
// Bench for mem_to_reg: table-driven transactions against a scripted peripheral, with a
// scoreboard of expected responses (data, error, arrival cycle) pushed at grant time.

module tb_mem_to_reg;

  import mem_to_reg_pkg::*;

  localparam int unsigned Tmo = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_cyc;   // ACCESS cycles before peripheral ready (>= Tmo: never)
    logic [31:0] prdata;
    logic        perr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // grant cycle to rvalid cycle
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  reg_req_t reg_req;
  reg_rsp_t rsp;

  mem_to_reg_if #(.AW(32), .DW(32)) mif ();

  mem_to_reg #(
    .AW(32),
    .DW(32),
    .TimeoutCycles(Tmo)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .mem      (mif),
    .reg_req_o(reg_req),
    .reg_rsp_i(rsp)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pcnt = 0;
  int   grant_cyc = 0;
  bit   granted = 0;
  bit   prev_valid = 0;
  bit   prev_ready = 0;
  bit   have_last = 0;
  logic [31:0] last_rdata;
  vec_t cur;
  vec_t plan_q[$];
  exp_t exp_q[$];
  vec_t vecs[8];
  vec_t bb[4];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int wait_cyc,
                              input logic [31:0] prdata, input logic perr,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.wait_cyc = wait_cyc;
    v.prdata = prdata; v.perr = perr; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cur = v;
    mif.req = 1'b1;
    mif.we = v.we;
    mif.addr = v.addr;
    mif.wdata = v.wdata;
    mif.wstrb = v.wstrb;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic tick();
    exp_t e;
    rsp = '0;
    rsp.rdata = 32'hBAD0BAD0;
    if (reg_req.valid && plan_q.size() > 0) begin
      rsp.ready = (pcnt == plan_q[0].wait_cyc);
      rsp.rdata = plan_q[0].prdata;
      rsp.error = plan_q[0].perr;
    end
    @(negedge clk);
    if (reg_req.valid) begin
      check("gnt_in_access", 128'(mif.gnt), 128'(0));
      if (plan_q.size() == 0) check("bus_valid_unexpected", 128'(reg_req.valid), 128'(0));
      else check("bus_fields", {reg_req.write, reg_req.addr, reg_req.wdata, reg_req.wstrb},
                 {plan_q[0].we, plan_q[0].addr, plan_q[0].wdata, plan_q[0].wstrb});
    end else begin
      check("idle_bus_zero", 128'(reg_req), 128'(0));
    end
    if (mif.rvalid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", 128'(mif.rvalid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("rdata", 128'(mif.rdata), 128'(e.rdata));
        check("rerror", 128'(mif.rerror), 128'(e.err));
        check("rvalid_cycle", 128'(cyc), 128'(e.cyc));
        check("valid_low_at_rsp", 128'(reg_req.valid), 128'(0));
        last_rdata = e.rdata;
        have_last = 1;
      end
    end else if (have_last) begin
      check("rdata_hold", 128'(mif.rdata), 128'(last_rdata));
    end
    if (mif.req && mif.gnt) begin
      plan_q.push_back(cur);
      e.rdata = cur.exp_rdata;
      e.err = cur.exp_err;
      e.cyc = cyc + cur.exp_lat;
      exp_q.push_back(e);
      grant_cyc = cyc;
      granted = 1;
    end
    prev_valid = reg_req.valid;
    prev_ready = rsp.ready;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_valid) begin
      if (prev_ready || !reg_req.valid) begin
        if (plan_q.size() > 0) void'(plan_q.pop_front());
        pcnt = 0;
      end else begin
        pcnt++;
      end
    end
  endtask

  task automatic wait_grant();
    granted = 0;
    for (int n = 0; n < 20 && !granted; n++) tick();
    if (!granted) check("grant_timeout", 128'(granted), 128'(1));
    mif.req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    check("response_pending", 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    wait_grant();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc[4];
    int idx;

    // Test vectors: {we, addr, wdata, wstrb, wait, periph rdata, periph err, exp rdata, exp err, lat}
    vecs[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hA5A5A5A5, 0, 32'h0, 0, 2);
    vecs[1] = mk(0, 32'h24, 32'h0, 4'h0, 4, 32'h12345678, 0, 32'h12345678, 0, 6);
    vecs[2] = mk(0, 32'h30, 32'h0, 4'h0, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 2);
    vecs[3] = mk(0, 32'h40, 32'h0, 4'h0, 99, 32'h11111111, 0, 32'h0, 1, 9);
    vecs[4] = mk(0, 32'h44, 32'h0, 4'h0, 7, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 9);
    vecs[5] = mk(1, 32'h08, 32'h01020304, 4'h3, 2, 32'h55555555, 1, 32'h0, 1, 4);
    vecs[6] = mk(1, 32'h100, 32'h0BADF00D, 4'h0, 99, 32'h77777777, 0, 32'h0, 1, 9);
    vecs[7] = mk(0, 32'hFFFFFFFC, 32'h0, 4'h0, 1, 32'h89ABCDEF, 0, 32'h89ABCDEF, 0, 3);
    for (int i = 0; i < 4; i++)
      bb[i] = mk(0, 32'h200 + 32'(4 * i), 32'h0, 4'h0, 0, 32'hB0B00000 + 32'(i), 0,
                 32'hB0B00000 + 32'(i), 0, 2);

    // Reset with req held high: gnt must stay low and all outputs at reset values.
    rst = 1'b1;
    rsp = '0;
    mif.req = 1'b1;
    mif.we = 1'b1;
    mif.addr = 32'h4;
    mif.wdata = 32'h1;
    mif.wstrb = 4'hF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_gnt", 128'(mif.gnt), 128'(0));
      check("rst_rvalid", 128'(mif.rvalid), 128'(0));
      check("rst_rdata", 128'(mif.rdata), 128'(0));
      check("rst_rerror", 128'(mif.rerror), 128'(0));
      check("rst_reg_req", 128'(reg_req), 128'(0));
      @(posedge clk);
      #1;
    end
    mif.req = 1'b0;
    rst = 1'b0;

    // Single transactions from the table.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back: req held high across four reads.
    idx = 0;
    drive(bb[0]);
    for (int n = 0; n < 40 && idx < 4; n++) begin
      granted = 0;
      tick();
      if (granted) begin
        gc[idx] = grant_cyc;
        idx++;
        if (idx < 4) drive(bb[idx]);
        else mif.req = 1'b0;
      end
    end
    mif.req = 1'b0;
    check("b2b_grants", 128'(idx), 128'(4));
    for (int i = 1; i < 4; i++) check("b2b_spacing", 128'(gc[i] - gc[i-1]), 128'(2));
    wait_idle();

    // Reset on the 2nd ACCESS cycle of a slow read: transaction discarded.
    drive(mk(0, 32'h60, 32'h0, 4'h0, 6, 32'h66666666, 0, 32'h66666666, 0, 8));
    wait_grant();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    have_last = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("rst_mid_rdata", 128'(mif.rdata), 128'(0));
    check("rst_mid_rerror", 128'(mif.rerror), 128'(0));
    check("rst_mid_rvalid", 128'(mif.rvalid), 128'(0));
    check("rst_mid_reg_req", 128'(reg_req), 128'(0));
    check("rst_mid_plan", 128'(plan_q.size()), 128'(0));
    @(posedge clk);
    #1;
    cyc++;
    run_vec(mk(1, 32'h14, 32'h13572468, 4'hC, 1, 32'h99999999, 0, 32'h0, 0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
